// File: rtl/toggle_activity_monitor.sv
// Windowed toggle counter: sums the Hamming distance between consecutive accepted
// code words and hands the total off over valid/ready. Define PER_BIT_COUNT_EN for per-bit counters.
module toggle_activity_monitor #(
    parameter int DATA_W  = 2,
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cont,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         out_toggles,
    output logic                     out_overflow,
`ifdef PER_BIT_COUNT_EN
    output logic [DATA_W*CNT_W-1:0]  out_bit_toggles,
`endif
    output logic                     busy
);

    localparam int SCNT_W = $clog2(WIN_LEN + 1);
    localparam int POP_W  = $clog2(DATA_W + 1);
    localparam int SUM_W  = CNT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ACCUM,
        HOLD
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [DATA_W-1:0]    r_prev;
    logic [CNT_W-1:0]     r_acc;
    logic [SCNT_W-1:0]    r_cnt;
    logic                 r_ovf;
    logic [CNT_W-1:0]     r_outToggles;
    logic                 r_outOvf;

    logic [DATA_W-1:0]    w_diff;
    logic [POP_W-1:0]     w_pop;
    logic [SUM_W-1:0]     w_sum;
    logic                 w_sat;
    logic [CNT_W-1:0]     w_accNext;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_xfer;
    logic                 w_clearWin;

    always_comb begin
        w_diff = r_prev ^ in_data;
        w_pop  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_pop = w_pop + POP_W'(w_diff[i]);
        end
        w_sum      = SUM_W'(r_acc) + SUM_W'(w_pop);
        w_sat      = (w_sum > SUM_W'(CNT_MAX));
        w_accNext  = w_sat ? CNT_MAX : w_sum[CNT_W-1:0];
        w_accept   = (r_state == ACCUM) && in_valid;
        w_last     = w_accept && (r_cnt == SCNT_W'(WIN_LEN - 1));
        w_xfer     = (r_state == HOLD) && out_ready;
        // A window restarts either from IDLE or straight after a continuous-mode hand-off.
        w_clearWin = ((r_state == IDLE) && start) || (w_xfer && cont);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start)    w_nextState = PRIME;
            PRIME:   if (in_valid) w_nextState = ACCUM;
            ACCUM:   if (w_last)   w_nextState = HOLD;
            HOLD:    if (out_ready) w_nextState = cont ? ACCUM : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_outToggles <= '0;
            r_outOvf     <= 1'b0;
        end else begin
            if (w_clearWin) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_accept) begin
                r_acc <= w_accNext;
                r_cnt <= r_cnt + SCNT_W'(1);
                r_ovf <= r_ovf | w_sat;
                if (w_last) begin
                    r_outToggles <= w_accNext;
                    r_outOvf     <= r_ovf | w_sat;
                end
            end
            // prev survives the hand-off so continuous windows need no priming sample.
            if (((r_state == PRIME) && in_valid) || w_accept) begin
                r_prev <= in_data;
            end
        end
    end

`ifdef PER_BIT_COUNT_EN
    logic [CNT_W-1:0] r_bitAcc [DATA_W];
    logic [CNT_W-1:0] r_bitOut [DATA_W];
    logic [CNT_W-1:0] w_bitNext [DATA_W];

    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            w_bitNext[i] = (w_diff[i] && (r_bitAcc[i] != CNT_MAX)) ?
                           r_bitAcc[i] + CNT_W'(1) : r_bitAcc[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DATA_W; i++) begin
                r_bitAcc[i] <= '0;
                r_bitOut[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (w_clearWin) begin
                    r_bitAcc[i] <= '0;
                end else if (w_accept) begin
                    r_bitAcc[i] <= w_bitNext[i];
                    if (w_last) begin
                        r_bitOut[i] <= w_bitNext[i];
                    end
                end
            end
        end
    end

    always_comb begin
        out_bit_toggles = '0;
        for (int i = 0; i < DATA_W; i++) begin
            out_bit_toggles[i*CNT_W +: CNT_W] = r_bitOut[i];
        end
    end
`endif

    assign out_valid    = (r_state == HOLD);
    assign busy         = (r_state != IDLE);
    assign out_toggles  = r_outToggles;
    assign out_overflow = r_outOvf;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Self-checking bench for toggle_activity_monitor: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based window model.
module tb_toggle_activity_monitor;

    localparam int     DW   = 2;
    localparam int     CW   = 16;
    localparam int     WIN  = 4;
    localparam int     SCW  = 3;
    localparam int     SWIN = 8;
    localparam longint MAXC = 65535;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          start = 1'b0, cont = 1'b0, inValid = 1'b0, outReady = 1'b0;
    logic [DW-1:0] inData = '0;
    logic          outValid, outOvf, busy;
    logic [CW-1:0] outTog;

    logic           sStart = 1'b0, sCont = 1'b0, sInValid = 1'b0, sOutReady = 1'b0;
    logic [DW-1:0]  sInData = '0;
    logic           sOutValid, sOutOvf, sBusy;
    logic [SCW-1:0] sOutTog;

`ifdef PER_BIT_COUNT_EN
    logic [DW*CW-1:0]  bitTog;
    logic [DW*SCW-1:0] sBitTog;
`endif

    always #5 clk = ~clk;

    toggle_activity_monitor #(.DATA_W(DW), .CNT_W(CW), .WIN_LEN(WIN)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .in_valid(inValid), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady),
        .out_toggles(outTog), .out_overflow(outOvf),
`ifdef PER_BIT_COUNT_EN
        .out_bit_toggles(bitTog),
`endif
        .busy(busy)
    );

    toggle_activity_monitor #(.DATA_W(DW), .CNT_W(SCW), .WIN_LEN(SWIN)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(sStart), .cont(sCont),
        .in_valid(sInValid), .in_data(sInData),
        .out_valid(sOutValid), .out_ready(sOutReady),
        .out_toggles(sOutTog), .out_overflow(sOutOvf),
`ifdef PER_BIT_COUNT_EN
        .out_bit_toggles(sBitTog),
`endif
        .busy(sBusy)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: a window is just the list of accepted samples; the result is
    // the sum of Hamming distances between neighbours, clamped to the counter range.
    bit            mBusy, mHold, mOvf;
    logic [DW-1:0] q[$];
    longint        mToggles;
    longint        mBit[DW];

    function void modelReset();
        mBusy    = 0;
        mHold    = 0;
        mOvf     = 0;
        mToggles = 0;
        q.delete();
        for (int b = 0; b < DW; b++) mBit[b] = 0;
    endfunction

    function void modelStep(bit st, bit ct, bit iv, logic [DW-1:0] d, bit rdy);
        longint        sum;
        longint        bs[DW];
        logic [DW-1:0] x;
        logic [DW-1:0] last;
        sum = 0;
        for (int b = 0; b < DW; b++) bs[b] = 0;
        if (!mBusy) begin
            if (st) begin
                mBusy = 1;
                q.delete();
            end
        end else if (mHold) begin
            if (rdy) begin
                mHold = 0;
                if (ct) begin
                    last = q[q.size()-1];
                    q.delete();
                    q.push_back(last);
                end else begin
                    mBusy = 0;
                end
            end
        end else if (iv) begin
            q.push_back(d);
            if (q.size() == WIN + 1) begin
                for (int k = 1; k < q.size(); k++) begin
                    x = q[k] ^ q[k-1];
                    sum += $countones(x);
                    for (int b = 0; b < DW; b++) bs[b] += longint'(x[b]);
                end
                mToggles = (sum > MAXC) ? MAXC : sum;
                mOvf     = (sum > MAXC);
                for (int b = 0; b < DW; b++) mBit[b] = (bs[b] > MAXC) ? MAXC : bs[b];
                mHold = 1;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("model.out_valid", longint'(outValid), longint'(mHold));
        checkOutput("model.busy", longint'(busy), longint'(mBusy));
        checkOutput("model.out_toggles", longint'(outTog), mToggles);
        if (mHold) begin
            checkOutput("model.out_overflow", longint'(outOvf), longint'(mOvf));
`ifdef PER_BIT_COUNT_EN
            for (int b = 0; b < DW; b++)
                checkOutput("model.out_bit_toggles", longint'(bitTog[b*CW +: CW]), mBit[b]);
`endif
        end
    endtask

    task automatic applyStimulus(input bit st, input bit ct, input bit iv,
                                 input logic [DW-1:0] d, input bit rdy);
        start    = st;
        cont     = ct;
        inValid  = iv;
        inData   = d;
        outReady = rdy;
        @(posedge clk);
        modelStep(st, ct, iv, d, rdy);
        #1;
        checkModel();
    endtask

    task automatic satStep(input bit st, input bit ct, input bit iv,
                           input logic [DW-1:0] d, input bit rdy);
        sStart    = st;
        sCont     = ct;
        sInValid  = iv;
        sInData   = d;
        sOutReady = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit            st;
        bit            ct;
        bit            iv;
        logic [DW-1:0] d;
        bit            rdy;
        bit            eValid;
        bit            eBusy;
        int            eTog;
    } vec_t;

    vec_t          basic[8];
    logic [DW-1:0] gseq[5];
    logic [DW-1:0] nseq[4];
    logic [DW-1:0] cseq[4];
    logic [DW-1:0] zseq[8];

    initial begin
        basic[0] = '{1, 0, 0, 2'b00, 0, 0, 1, 0};
        basic[1] = '{0, 0, 1, 2'b00, 0, 0, 1, 0};
        basic[2] = '{0, 0, 1, 2'b01, 0, 0, 1, 0};
        basic[3] = '{0, 0, 1, 2'b10, 0, 0, 1, 0};
        basic[4] = '{0, 0, 1, 2'b11, 0, 0, 1, 0};
        basic[5] = '{0, 0, 1, 2'b00, 0, 1, 1, 6};
        basic[6] = '{0, 0, 0, 2'b00, 0, 1, 1, 6};
        basic[7] = '{0, 0, 0, 2'b00, 1, 0, 0, 6};
        gseq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        nseq = '{2'b11, 2'b00, 2'b01, 2'b00};
        cseq = '{2'b01, 2'b01, 2'b01, 2'b11};
        zseq = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        modelReset();

        #12;
        checkOutput("reset.out_valid", longint'(outValid), 0);
        checkOutput("reset.busy", longint'(busy), 0);
        checkOutput("reset.out_toggles", longint'(outTog), 0);
        checkOutput("reset.out_overflow", longint'(outOvf), 0);
        releaseReset();

        // Idle robustness: traffic on in_valid without start must not wake the block.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 2'b11, 1);
        checkOutput("idle.busy", longint'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(basic[i].st, basic[i].ct, basic[i].iv, basic[i].d, basic[i].rdy);
            checkOutput("basic.out_valid", longint'(outValid), longint'(basic[i].eValid));
            checkOutput("basic.busy", longint'(busy), longint'(basic[i].eBusy));
            checkOutput("basic.out_toggles", longint'(outTog), longint'(basic[i].eTog));
`ifdef PER_BIT_COUNT_EN
            if (i == 5) begin
                checkOutput("basic.bit0", longint'(bitTog[0 +: CW]), 4);
                checkOutput("basic.bit1", longint'(bitTog[CW +: CW]), 2);
            end
`endif
        end

        // Gapped samples with start held high throughout, then backpressure in HOLD.
        applyStimulus(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, (i % 2) == 1, gseq[i/2], 0);
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1, 0, j < 2, 2'b11, 0);
            checkOutput("hold.out_toggles", longint'(outTog), 6);
            checkOutput("hold.out_valid", longint'(outValid), 1);
        end
        applyStimulus(0, 1, 1, 2'b11, 1);
        checkOutput("handshake.out_valid", longint'(outValid), 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, nseq[i], 0);
        checkOutput("dropInHold.out_toggles", longint'(outTog), 6);
        checkOutput("dropInHold.out_valid", longint'(outValid), 1);

        // Continuous mode: last sample 00 carries over as the reference.
        applyStimulus(0, 1, 0, 2'b00, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, cseq[i], 0);
        checkOutput("cont.out_toggles", longint'(outTog), 2);
        checkOutput("cont.out_valid", longint'(outValid), 1);
        applyStimulus(0, 0, 0, 2'b00, 1);
        checkOutput("cont.busyAfter", longint'(busy), 0);

        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1);
        end

        // Reset mid-window after a completed window has loaded a nonzero result.
        #2; rst_n = 1'b0; #1; modelReset();
        releaseReset();
        applyStimulus(1, 0, 0, 2'b00, 0);
        applyStimulus(0, 0, 1, 2'b00, 0);
        applyStimulus(0, 0, 1, 2'b11, 0);
        applyStimulus(0, 0, 1, 2'b11, 0);
        applyStimulus(0, 0, 1, 2'b11, 0);
        applyStimulus(0, 0, 1, 2'b10, 0);
        checkOutput("prior.out_toggles", longint'(outTog), 3);
        applyStimulus(0, 0, 0, 2'b00, 1);
        applyStimulus(1, 0, 0, 2'b00, 0);
        applyStimulus(0, 0, 1, 2'b00, 0);
        applyStimulus(0, 0, 1, 2'b01, 0);
        applyStimulus(0, 0, 1, 2'b11, 0);
        #2; rst_n = 1'b0; #1; modelReset();
        checkOutput("midReset.out_valid", longint'(outValid), 0);
        checkOutput("midReset.busy", longint'(busy), 0);
        checkOutput("midReset.out_toggles", longint'(outTog), 0);
        releaseReset();
        applyStimulus(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, gseq[i], 0);
        checkOutput("afterReset.out_toggles", longint'(outTog), 6);
        applyStimulus(0, 0, 0, 2'b00, 1);
        start = 1'b0;

        // Saturation on the narrow instance: 8 comparisons of 2 toggles each.
        satStep(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 9; i++) satStep(0, 0, 1, (i % 2 == 0) ? 2'b00 : 2'b11, 0);
        checkOutput("sat.out_valid", longint'(sOutValid), 1);
        checkOutput("sat.out_toggles", longint'(sOutTog), 7);
        checkOutput("sat.out_overflow", longint'(sOutOvf), 1);
`ifdef PER_BIT_COUNT_EN
        checkOutput("sat.bit0", longint'(sBitTog[0 +: SCW]), 7);
`endif
        satStep(0, 1, 0, 2'b00, 1);
        for (int i = 0; i < 8; i++) satStep(0, 0, 1, zseq[i], 0);
        checkOutput("satNext.out_valid", longint'(sOutValid), 1);
        checkOutput("satNext.out_toggles", longint'(sOutTog), 1);
        checkOutput("satNext.out_overflow", longint'(sOutOvf), 0);
        satStep(0, 0, 0, 2'b00, 1);
        checkOutput("satNext.busy", longint'(sBusy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/toggle_activity_monitor.md
Name: toggle_activity_monitor

Overview:
Downstream consumer of the 4-to-2 encoder output bus. It samples the encoded code word, counts bit toggles (Hamming distance between consecutive accepted samples) over a fixed window of comparisons, and hands the switching-activity count to the power-estimation datapath through a valid/ready handshake. It provides a synthesizable, on-chip equivalent of the VCD-based toggle counting used in gate-level power runs.

Parameters:
DATA_W, 2, width of monitored bus (encoder output width)
CNT_W, 16, width of toggle accumulator; saturating
WIN_LEN, 64, comparisons per window (>=1); sample counter width = clog2(WIN_LEN+1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level-sampled; begins a window when the block is IDLE
cont  input  1  sampled at the output handshake; 1 = start next window immediately
in_valid  input  1  in_data qualifier
in_data  input  DATA_W  monitored code word (encoder out)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_toggles  output  CNT_W  total toggles in the window
out_overflow  output  1  accumulator saturated during the window
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; prev, acc, sample count cleared; out_valid=0, out_toggles=0, out_overflow=0, busy=0. Reset asserted mid-window discards the window; no partial result is emitted.
- FSM states: IDLE, PRIME, ACCUM, HOLD.
- IDLE: start=1 -> PRIME; clear acc, count, overflow. in_valid is ignored.
- PRIME: first accepted sample (in_valid=1) loads prev; no toggles counted -> ACCUM.
- ACCUM: each accepted sample: acc += popcount(prev ^ in_data); prev <= in_data; count++. The add saturates at 2^CNT_W-1 and sets the sticky overflow flag. Cycles with in_valid=0 change nothing. The accepted sample that brings count to WIN_LEN -> HOLD.
- HOLD: out_valid=1 the cycle after the WIN_LEN-th comparison. out_toggles and out_overflow are registered and stable until the handshake; in_valid samples are dropped and prev is not updated.
- Handshake: the transfer completes on a cycle where out_valid and out_ready are both 1. out_valid deasserts on the next cycle. out_ready while not in HOLD has no effect.
  - cont=1 at transfer: go to ACCUM with acc, count, overflow cleared. prev keeps the last window's final sample, so there is no priming gap.
  - cont=0 at transfer: go to IDLE.
- start outside IDLE is ignored.
- Latency: from the last accepted sample to out_valid is 1 cycle. Minimum window length is WIN_LEN+1 accepted samples from IDLE, and WIN_LEN samples in continuous mode.
- out_toggles holds the last delivered value after a handshake. It is cleared only by reset.

Optional Feature:
PER_BIT_COUNT_EN. When defined, the block adds the output port out_bit_toggles, width DATA_W*CNT_W.
- Slice [i*CNT_W +: CNT_W] counts toggles of bit i.
- Each counter saturates independently.
- Each counter is cleared, captured and held exactly like out_toggles.
When the macro is not defined, the port and its counters do not exist, and the total-count behaviour is unchanged.

Test Plan:
- Basic window (DATA_W=2, WIN_LEN=4): reset, start, samples 00,01,10,11,00 -> out_valid 1 cycle after the 5th sample; out_toggles=6; overflow=0. With PER_BIT_COUNT_EN: bit0=4, bit1=2.
- Gaps and backpressure: the same samples with in_valid low on alternate cycles, and out_ready held low for 5 cycles -> same result 6. Output is stable while held. Samples 11,11 offered during HOLD do not change the next window.
- Saturation (CNT_W=3, WIN_LEN=8): alternate 00/11 for 9 samples -> out_toggles=7, out_overflow=1. Overflow clears at the next window start.
- Continuous mode: cont=1 at the handshake, last sample 00, next samples 01,01,01,11 -> second window out_toggles=2 with no priming sample.
- Reset mid-operation: rst_n low after 2 comparisons -> out_valid=0, busy=0, out_toggles=0 immediately (async). The next window from start counts from zero.
- Idle robustness: in_valid activity in IDLE and start pulses during ACCUM/HOLD -> no state change, no extra out_valid.
